// File: rtl/ysyx_25050147_pkg.sv
// Shared fetch-stage types: FSM state encoding, response codes and the
// {pc, inst, fault} bundle handed from fetch to decode.
`timescale 1ns/1ps
package ysyx_25050147_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_OUT,
      S_NPC
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [1:0]  RESP_OKAY        = 2'b00;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } fetch_bundle_t;

   function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
      return pc_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_25050147_fetch.sv
// Multi-cycle instruction fetch: one outstanding read on a handshaked
// read-only port, bundle presented to decode, then waits for the next PC.
`timescale 1ns/1ps
module ysyx_25050147_fetch
   import ysyx_25050147_pkg::*;
#(
   parameter int unsigned          ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [31:0]       out_inst,
   output logic              out_fault,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic [ADDR_W-1:0] npc,
   input  logic              npc_valid,
   output logic [31:0]       fetch_cnt
);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [31:0]       inst_q;
   logic              fault_q;
   logic              arvalid_q;
   logic              rready_q;
   logic              out_valid_q;
   logic [31:0]       cnt_q;
   logic [31:0]       cnt_d;

   always_comb begin
      cnt_d = cnt_q + 32'd1;
   end

   // Handshake outputs are registered alongside the state they belong to,
   // so each one is set on the transition into its state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         inst_q      <= '0;
         fault_q     <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               arvalid_q <= !pc_misaligned(pc_q[1:0]);
               state_q   <= S_REQ;
            end
            S_REQ: begin
               if (pc_misaligned(pc_q[1:0])) begin
                  inst_q      <= '0;
                  fault_q     <= 1'b1;
                  arvalid_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_OUT;
               end else if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (rvalid) begin
                  inst_q      <= rdata;
                  fault_q     <= (rresp != RESP_OKAY);
                  rready_q    <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_OUT;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  cnt_q       <= cnt_d;
                  state_q     <= S_NPC;
               end
            end
            S_NPC: begin
               if (npc_valid) begin
                  pc_q      <= npc;
                  arvalid_q <= !pc_misaligned(npc[1:0]);
                  state_q   <= S_REQ;
               end
            end
            default: begin
               arvalid_q   <= 1'b0;
               rready_q    <= 1'b0;
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign araddr    = pc_q;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;
   assign out_pc    = pc_q;
   assign out_inst  = inst_q;
   assign out_fault = fault_q;
   assign out_valid = out_valid_q;
   assign fetch_cnt = cnt_q;

endmodule
